edge_detect: RTL and testbench

- Pipelined Sobel edge detector for the Cartoonifier image path.
- Takes one 3x3 window of 8-bit luminance pixels per cycle and computes gradient magnitude |Gx|+|Gy|.
- Flags the centre pixel as an edge when the magnitude strictly exceeds a runtime threshold.
- Sits between the window/line-buffer stage and the pixel recolouring stage; the downstream stage substitutes edge colour where isEdge=1 and passes the original pixel otherwise.

---
 rtl/edge_detect.sv | 100 ++++++++++
 tb/tb_edge_detect.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/edge_detect.sv
// Two-stage pipelined Sobel edge detector (|Gx|+|Gy| > threshold); 2-cycle latency, no backpressure.
// Define EDGE_DIAG_EN to also compute diagonal kernels and use max(|Gx|+|Gy|, |Gd1|+|Gd2|).
module edge_detect #(
  parameter int PIXEL_W = 8,
  parameter int MAG_W   = PIXEL_W + 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 iValid,
  input  logic [MAG_W-1:0]     iThreshold,
  input  logic [9*PIXEL_W-1:0] iGrid,
  output logic                 isEdge,
  output logic [MAG_W-1:0]     oMagnitude,
  output logic                 oValid
);

  logic [MAG_W-1:0] p [9];
  logic [MAG_W-1:0] gx_c, gy_c;
  logic [MAG_W-1:0] gx_q, gy_q, thr_q;
  logic             v1;
  logic [MAG_W-1:0] mag_c;

  // (a + 2b + c) - (d + 2e + f); the MAG_W-bit result is read as two's complement
  function automatic logic [MAG_W-1:0] sobel(input logic [MAG_W-1:0] a, b, c, d, e, f);
    return (a + (b << 1) + c) - (d + (e << 1) + f);
  endfunction

  function automatic logic [MAG_W-1:0] abs_val(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      p[k] = MAG_W'(iGrid[PIXEL_W*k +: PIXEL_W]);
    end
  end

  assign gx_c = sobel(p[2], p[5], p[8], p[0], p[3], p[6]);
  assign gy_c = sobel(p[6], p[7], p[8], p[0], p[1], p[2]);

`ifdef EDGE_DIAG_EN
  logic [MAG_W-1:0] gd1_c, gd2_c, gd1_q, gd2_q, mag_d;

  assign gd1_c = sobel(p[1], p[2], p[5], p[3], p[6], p[7]);
  assign gd2_c = sobel(p[1], p[0], p[3], p[5], p[8], p[7]);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gd1_q <= '0;
      gd2_q <= '0;
    end else if (iValid) begin
      gd1_q <= gd1_c;
      gd2_q <= gd2_c;
    end
  end

  always_comb begin
    mag_c = abs_val(gx_q) + abs_val(gy_q);
    mag_d = abs_val(gd1_q) + abs_val(gd2_q);
    if (mag_d > mag_c) mag_c = mag_d;
  end
`else
  always_comb begin
    mag_c = abs_val(gx_q) + abs_val(gy_q);
  end
`endif

  // Stage 1: gradients and the threshold that travels with this window
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1    <= 1'b0;
      gx_q  <= '0;
      gy_q  <= '0;
      thr_q <= '0;
    end else begin
      v1 <= iValid;
      if (iValid) begin
        gx_q  <= gx_c;
        gy_q  <= gy_c;
        thr_q <= iThreshold;
      end
    end
  end

  // Stage 2: magnitude and strict compare; outputs hold through bubbles
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oValid     <= 1'b0;
      oMagnitude <= '0;
      isEdge     <= 1'b0;
    end else begin
      oValid <= v1;
      if (v1) begin
        oMagnitude <= mag_c;
        isEdge     <= (mag_c > thr_q);
      end
    end
  end

endmodule

// File: tb/tb_edge_detect.sv
// Directed bench for edge_detect: single windows, threshold boundaries, streaming with a gap, reset flush.
module tb_edge_detect;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        iValid;
  logic [10:0] iThreshold;
  logic [71:0] iGrid;
  logic        isEdge;
  logic [10:0] oMagnitude;
  logic        oValid;

  int total = 0;
  int passed = 0;

  edge_detect dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .iValid     (iValid),
    .iThreshold (iThreshold),
    .iGrid      (iGrid),
    .isEdge     (isEdge),
    .oMagnitude (oMagnitude),
    .oValid     (oValid)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] g9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one window, then check the bubble before it, its result, and the hold after it
  task automatic run_one(input string tag, input logic [71:0] g, input logic [10:0] thr,
                         input logic [10:0] exp_mag, input logic exp_edge);
    iValid = 1'b1; iGrid = g; iThreshold = thr;
    step();
    iValid = 1'b0; iGrid = '0; iThreshold = '0;
    chk({tag, "_v_lat1"}, oValid, 0);
    step();
    chk({tag, "_v"},    oValid, 1);
    chk({tag, "_mag"},  oMagnitude, exp_mag);
    chk({tag, "_edge"}, isEdge, exp_edge);
    step();
    chk({tag, "_v_after"},  oValid, 0);
    chk({tag, "_mag_hold"}, oMagnitude, exp_mag);
  endtask

  localparam logic [7:0] H = 8'd255;

`ifdef EDGE_DIAG_EN
  localparam logic [10:0] EXP_V = 11'd1530;  // diagonal terms 765+765 dominate 1020
`else
  localparam logic [10:0] EXP_V = 11'd1020;
`endif
  localparam logic [10:0] EXP_M = 11'd1530;
  localparam logic [10:0] EXP_A = 11'd1530;
  localparam logic [10:0] EXP_D = 11'd1530;

  logic [71:0] g_u, g_v, g_m, g_a, g_d;
  logic [71:0] s_grid [10];
  logic        s_vld  [10];
  logic [10:0] s_mag  [10];
  logic [10:0] last_mag;
  logic        last_edge;

  initial begin
    g_u = g9(100, 100, 100, 100, 100, 100, 100, 100, 100);
    g_v = g9(0, 0, H, 0, 0, H, 0, 0, H);
    g_m = g9(0, 0, H, 0, 0, H, H, H, H);
    g_a = g9(0, H, H, 0, 0, H, 0, 0, H);
    g_d = g9(H, H, 0, H, 0, 0, 0, 0, 0);

    n_rst = 1'b0; iValid = 1'b0; iThreshold = '0; iGrid = '0;
    #3;
    chk("rst_v", oValid, 0);
    chk("rst_mag", oMagnitude, 0);
    chk("rst_edge", isEdge, 0);
    step();
    step();
    n_rst = 1'b1;
    step();
    chk("idle_v", oValid, 0);

    run_one("uniform", g_u, 11'd0, 11'd0, 1'b0);
    run_one("vert_below", g_v, EXP_V - 11'd1, EXP_V, 1'b1);
    run_one("vert_equal", g_v, EXP_V, EXP_V, 1'b0);
    run_one("max_below", g_m, EXP_M - 11'd1, EXP_M, 1'b1);
    run_one("max_equal", g_m, EXP_M, EXP_M, 1'b0);
    run_one("max_thr2040", g_m, 11'd2040, EXP_M, 1'b0);
    run_one("antidiag", g_a, 11'd0, EXP_A, 1'b1);
    run_one("diag", g_d, 11'd2047, EXP_D, 1'b0);

    // Stream: five back-to-back windows, a gap, one more window, then idle
    s_vld[0] = 1; s_grid[0] = g_u; s_mag[0] = 0;
    s_vld[1] = 1; s_grid[1] = g_v; s_mag[1] = EXP_V;
    s_vld[2] = 1; s_grid[2] = g_u; s_mag[2] = 0;
    s_vld[3] = 1; s_grid[3] = g_m; s_mag[3] = EXP_M;
    s_vld[4] = 1; s_grid[4] = g_u; s_mag[4] = 0;
    s_vld[5] = 0; s_grid[5] = g_m; s_mag[5] = 0;
    s_vld[6] = 1; s_grid[6] = g_v; s_mag[6] = EXP_V;
    s_vld[7] = 0; s_grid[7] = g_u; s_mag[7] = 0;
    s_vld[8] = 0; s_grid[8] = g_u; s_mag[8] = 0;
    s_vld[9] = 0; s_grid[9] = g_u; s_mag[9] = 0;
    last_mag = EXP_M;
    last_edge = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iValid = s_vld[i]; iGrid = s_grid[i]; iThreshold = 11'd500;
      step();
      if (i >= 1) begin
        chk($sformatf("stream%0d_v", i - 1), oValid, s_vld[i-1]);
        if (s_vld[i-1]) begin
          last_mag = s_mag[i-1];
          last_edge = (s_mag[i-1] > 11'd500);
        end
        chk($sformatf("stream%0d_mag", i - 1), oMagnitude, last_mag);
        chk($sformatf("stream%0d_edge", i - 1), isEdge, last_edge);
      end
    end

    // Threshold travels with its own window
    iValid = 1'b1; iGrid = g_v; iThreshold = 11'd0;
    step();
    iGrid = g_v; iThreshold = 11'd2047;
    step();
    iValid = 1'b0;
    chk("thr_a_edge", isEdge, 1);
    step();
    chk("thr_b_edge", isEdge, 0);
    chk("thr_b_v", oValid, 1);

    // Reset with two windows in flight
    iValid = 1'b1; iGrid = g_v; iThreshold = 11'd0;
    step();
    iGrid = g_m;
    step();
    iValid = 1'b0;
    chk("pre_rst_v", oValid, 1);
    #1;
    n_rst = 1'b0;
    #1;
    chk("midrst_v", oValid, 0);
    chk("midrst_mag", oMagnitude, 0);
    chk("midrst_edge", isEdge, 0);
    #1;
    n_rst = 1'b1;
    step();
    chk("post_rst_v1", oValid, 0);
    step();
    chk("post_rst_v2", oValid, 0);
    chk("post_rst_mag", oMagnitude, 0);
    run_one("post_rst_fresh", g_m, 11'd0, EXP_M, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
